// File: rtl/down_timer_if.sv
// Register-style control/status bundle for the down timer.
// The slave side is the timer; the master side is the controlling agent.
interface down_timer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clr_i;
  logic             en_i;
  logic             we_i;
  logic [WIDTH-1:0] dat_i;
  logic             mode_i;
  logic             irq_ack_i;
  logic [WIDTH-1:0] dat_o;
  logic             tc_o;
  logic             irq_o;
  logic             busy_o;

  modport slave (
    input  clr_i, en_i, we_i, dat_i, mode_i, irq_ack_i,
    output dat_o, tc_o, irq_o, busy_o
  );

  modport master (
    output clr_i, en_i, we_i, dat_i, mode_i, irq_ack_i,
    input  dat_o, tc_o, irq_o, busy_o
  );
endinterface

// File: rtl/down_timer.sv
// Programmable down-counting timer with one-shot and periodic auto-reload modes,
// a one-cycle terminal-count pulse and a sticky, acknowledgeable interrupt.
module down_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  down_timer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             irq_q;
  logic             busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // Defaults: tc is a single-cycle pulse; ack clears irq unless tc sets it below.
      tc_q  <= 1'b0;
      irq_q <= irq_q & ~bus.irq_ack_i;
      if (bus.clr_i) begin
        cnt_q   <= '0;
        state_q <= StIdle;
        busy_q  <= 1'b0;
        irq_q   <= 1'b0;
      end else if (bus.we_i) begin
        reload_q <= bus.dat_i;
        cnt_q    <= bus.dat_i;
        state_q  <= StIdle;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.en_i && (cnt_q != '0)) begin
              state_q <= StRun;
              busy_q  <= 1'b1;
            end
          end
          StRun: begin
            if (bus.en_i) begin
              if (cnt_q > One) begin
                cnt_q <= cnt_q - One;
              end else if (cnt_q == One) begin
                tc_q  <= 1'b1;
                irq_q <= 1'b1;
                if (bus.mode_i && (reload_q != '0)) begin
                  cnt_q <= reload_q;
                end else begin
                  cnt_q   <= '0;
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                end
              end else begin
                // Zero count in RUN is unreachable; park safely without a pulse.
                state_q <= StDone;
                busy_q  <= 1'b0;
              end
            end
          end
          StDone: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dat_o  = cnt_q;
  assign bus.tc_o   = tc_q;
  assign bus.irq_o  = irq_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector tables plus hand-written sequences,
// with expected outputs queued at drive time and compared one edge later.
module tb_down_timer;

  logic clk;
  logic rst;

  down_timer_if #(.WIDTH(8)) bus ();

  down_timer #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       we;
    logic       en;
    logic       mode;
    logic       ack;
    logic [7:0] dat;
    logic [7:0] e_dat;
    logic       e_tc;
    logic       e_irq;
    logic       e_busy;
  } vec_t;

  typedef struct {
    string      name;
    logic [10:0] e;
  } sb_t;

  sb_t  sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input string name, input logic clr, input logic we, input logic en,
                             input logic mode, input logic ack, input logic [7:0] dat,
                             input logic [7:0] e_dat, input logic e_tc, input logic e_irq,
                             input logic e_busy);
    vec_t r;
    r.name = name; r.clr = clr; r.we = we; r.en = en; r.mode = mode; r.ack = ack;
    r.dat = dat; r.e_dat = e_dat; r.e_tc = e_tc; r.e_irq = e_irq; r.e_busy = e_busy;
    return r;
  endfunction

  task automatic compare(input string name, input logic [10:0] exp_v);
    logic [10:0] got;
    got = {bus.dat_o, bus.tc_o, bus.irq_o, bus.busy_o};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got dat=%02h tc=%b irq=%b busy=%b, expected dat=%02h tc=%b irq=%b busy=%b",
               name, got[10:3], got[2], got[1], got[0],
               exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Scoreboard checker: each drive pushes one expectation, consumed just after the next edge.
  always @(posedge clk) begin
    sb_t s;
    #1;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      compare(s.name, s.e);
    end
  end

  task automatic drive(input vec_t t);
    sb_t s;
    @(negedge clk);
    bus.clr_i     = t.clr;
    bus.we_i      = t.we;
    bus.en_i      = t.en;
    bus.mode_i    = t.mode;
    bus.irq_ack_i = t.ack;
    bus.dat_i     = t.dat;
    s.name = t.name;
    s.e    = {t.e_dat, t.e_tc, t.e_irq, t.e_busy};
    sb_q.push_back(s);
  endtask

  task automatic run_table(input vec_t tbl[$]);
    foreach (tbl[i]) drive(tbl[i]);
  endtask

  vec_t tbl_oneshot[$];
  vec_t tbl_irq[$];
  vec_t tbl_clr[$];

  initial begin
    // One-shot load of 5, then terminal count.
    tbl_oneshot.push_back(v("reset_idle", 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl_oneshot.push_back(v("os_load",    0, 1, 0, 0, 0, 8'h05, 8'h05, 0, 0, 0));
    tbl_oneshot.push_back(v("os_start",   0, 0, 1, 0, 0, 8'h00, 8'h05, 0, 0, 1));
    tbl_oneshot.push_back(v("os_04",      0, 0, 1, 0, 0, 8'h00, 8'h04, 0, 0, 1));
    tbl_oneshot.push_back(v("os_03",      0, 0, 1, 0, 0, 8'h00, 8'h03, 0, 0, 1));
    tbl_oneshot.push_back(v("os_02",      0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0, 1));
    tbl_oneshot.push_back(v("os_01",      0, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 1));
    tbl_oneshot.push_back(v("os_tc",      0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0));
    // Ack, zero load, reload of 1 in periodic mode.
    tbl_irq.push_back(v("ack_clear",   0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0));
    tbl_irq.push_back(v("load_zero",   0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl_irq.push_back(v("zero_norun",  0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl_irq.push_back(v("load_one",    0, 1, 0, 1, 0, 8'h01, 8'h01, 0, 0, 0));
    tbl_irq.push_back(v("one_start",   0, 0, 1, 1, 0, 8'h00, 8'h01, 0, 0, 1));
    tbl_irq.push_back(v("one_tc_a",    0, 0, 1, 1, 0, 8'h00, 8'h01, 1, 1, 1));
    tbl_irq.push_back(v("one_tc_b",    0, 0, 1, 1, 0, 8'h00, 8'h01, 1, 1, 1));
    tbl_irq.push_back(v("load_three",  0, 1, 0, 1, 0, 8'h03, 8'h03, 0, 1, 0));
    tbl_irq.push_back(v("ack_idle",    0, 0, 0, 1, 1, 8'h00, 8'h03, 0, 0, 0));
    // Clear beats load; later load mid-RUN restarts from IDLE.
    tbl_clr.push_back(v("clr_vs_we",   1, 1, 1, 1, 0, 8'h7F, 8'h00, 0, 0, 0));
    tbl_clr.push_back(v("clr_idle",    0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 0, 0));
    tbl_clr.push_back(v("load_a5",     0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0, 0));
    tbl_clr.push_back(v("a5_start",    0, 0, 1, 0, 0, 8'h00, 8'hA5, 0, 0, 1));
    tbl_clr.push_back(v("a5_dec",      0, 0, 1, 0, 0, 8'h00, 8'hA4, 0, 0, 1));
    tbl_clr.push_back(v("load_in_run", 0, 1, 1, 0, 0, 8'h02, 8'h02, 0, 0, 0));
    tbl_clr.push_back(v("re_start",    0, 0, 1, 0, 0, 8'h00, 8'h02, 0, 0, 1));
    tbl_clr.push_back(v("re_01",       0, 0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 1));
    tbl_clr.push_back(v("re_tc",       0, 0, 1, 0, 0, 8'h00, 8'h00, 1, 1, 0));

    rst = 1'b1;
    bus.clr_i = 0; bus.we_i = 0; bus.en_i = 0; bus.mode_i = 0; bus.irq_ack_i = 0;
    bus.dat_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    compare("in_reset", 11'h000);
    @(negedge clk);
    rst = 1'b0;

    run_table(tbl_oneshot);
    for (int i = 0; i < 20; i++) drive(v("done_hold", 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 0));

    run_table(tbl_irq);

    // Periodic reload 3: 03,02,01,03,... after the start cycle; tc on each reload.
    for (int k = 1; k <= 12; k++) begin
      logic [7:0] val;
      val = (k % 3 == 0) ? 8'h01 : ((k % 3 == 1) ? 8'h03 : 8'h02);
      drive(v("periodic", 0, 0, 1, 1, 0, 8'h00, val, (k > 1) && (val == 8'h03), k >= 4, 1));
    end
    drive(v("ack_at_tc",   0, 0, 1, 1, 1, 8'h00, 8'h03, 1, 1, 1));
    drive(v("ack_alone",   0, 0, 1, 1, 1, 8'h00, 8'h02, 0, 0, 1));
    for (int i = 0; i < 10; i++) drive(v("pause", 0, 0, 0, 1, 0, 8'h00, 8'h02, 0, 0, 1));
    drive(v("resume",      0, 0, 1, 1, 0, 8'h00, 8'h01, 0, 0, 1));
    drive(v("resume_tc",   0, 0, 1, 1, 0, 8'h00, 8'h03, 1, 1, 1));

    run_table(tbl_clr);

    // Asynchronous reset mid-RUN: outputs must drop before the next edge.
    drive(v("ar_load",     0, 1, 0, 0, 0, 8'h05, 8'h05, 0, 1, 0));
    drive(v("ar_start",    0, 0, 1, 0, 0, 8'h00, 8'h05, 0, 1, 1));
    drive(v("ar_dec",      0, 0, 1, 0, 0, 8'h00, 8'h04, 0, 1, 1));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    compare("async_reset", 11'h000);
    @(negedge clk);
    rst = 1'b0;
    drive(v("post_reset",  0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    @(posedge clk);
    #2;

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
